// File: rtl/handshake_rr_control_merge.sv
// Round-robin control merge: N valid/ready producers share one registered output slot tagged with the winning index.
// Optional per-input saturating grant counters are enabled by defining HANDSHAKE_RR_CMERGE_GRANT_CNT_EN.
module handshake_rr_control_merge #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic [INDEX_WIDTH-1:0]           index,
  output logic                             outs_valid,
`ifdef HANDSHAKE_RR_CMERGE_GRANT_CNT_EN
  output logic [NUM_INPUTS*16-1:0]         grant_cnt,
`endif
  input  logic                             outs_ready
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 16 || (2 ** INDEX_WIDTH) < NUM_INPUTS) begin : g_bad_param
    $error("handshake_rr_control_merge: illegal NUM_INPUTS/INDEX_WIDTH combination");
  end

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

  logic [DATA_WIDTH-1:0]  outs_q, outs_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   outs_valid_q, outs_valid_d;
  logic [INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_INPUTS-1:0]  at_or_after_ptr;
  logic [NUM_INPUTS-1:0]  hi_req;
  logic                   grant_vld;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic [DATA_WIDTH-1:0]  grant_data;
  logic                   accept;
  logic                   xfer;
  logic                   consume;

  // Arbitration: lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    at_or_after_ptr = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      at_or_after_ptr[i] = (i >= int'(rr_ptr_q));
    end
    hi_req    = ins_valid & at_or_after_ptr;
    grant_vld = |ins_valid;
    grant_idx = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (ins_valid[i]) grant_idx = i[INDEX_WIDTH-1:0];
    end
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (hi_req[i]) grant_idx = i[INDEX_WIDTH-1:0];
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == i[INDEX_WIDTH-1:0]) grant_data = ins[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign accept  = !outs_valid_q || outs_ready;
  assign xfer    = grant_vld && accept && !rst;
  assign consume = outs_valid_q && outs_ready;

  always_comb begin
    ins_ready = '0;
    if (xfer) ins_ready[grant_idx] = 1'b1;
  end

  // Output slot: a transfer reloads it (even while being consumed); a bare consume empties it.
  always_comb begin
    outs_d       = outs_q;
    index_d      = index_q;
    outs_valid_d = outs_valid_q;
    rr_ptr_d     = rr_ptr_q;
    if (xfer) begin
      outs_d       = grant_data;
      index_d      = grant_idx;
      outs_valid_d = 1'b1;
      rr_ptr_d     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end else if (consume) begin
      outs_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q       <= '0;
      index_q      <= '0;
      outs_valid_q <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      outs_q       <= outs_d;
      index_q      <= index_d;
      outs_valid_q <= outs_valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign outs       = outs_q;
  assign index      = index_q;
  assign outs_valid = outs_valid_q;

`ifdef HANDSHAKE_RR_CMERGE_GRANT_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_q [NUM_INPUTS];
  logic [15:0] cnt_d [NUM_INPUTS];

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (xfer && grant_idx == i[INDEX_WIDTH-1:0]) cnt_d[i] = sat_inc16(cnt_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_handshake_rr_control_merge.sv
// Directed bench for handshake_rr_control_merge: a reference arbiter model predicts grants and pushes
// expected tokens into a scoreboard queue that is popped whenever the DUT output is consumed.
module tb_handshake_rr_control_merge;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   ins;
  logic [N-1:0]      ins_valid;
  logic [N-1:0]      ins_ready;
  logic [DW-1:0]     outs;
  logic [IW-1:0]     index;
  logic              outs_valid;
  logic              outs_ready;
`ifdef HANDSHAKE_RR_CMERGE_GRANT_CNT_EN
  logic [N*16-1:0]   grant_cnt;
`endif

  always #5 clk = ~clk;

  handshake_rr_control_merge #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .outs      (outs),
    .index     (index),
    .outs_valid(outs_valid),
`ifdef HANDSHAKE_RR_CMERGE_GRANT_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .outs_ready(outs_ready)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW+IW-1:0] sb[$];
  int               m_rr   = 0;
  bit               m_full = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant(input logic [N-1:0] v, input int rr);
    for (int off = 0; off < N; off++) begin
      int c;
      c = (rr + off) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock with the currently driven inputs; returns 1 time unit after the rising edge.
  task automatic step();
    int               g;
    bit               acc;
    logic [N-1:0]     exp_rdy;
    logic [DW+IW-1:0] e;
    #1;
    acc     = !m_full || outs_ready;
    g       = m_grant(ins_valid, m_rr);
    exp_rdy = '0;
    if (!rst && acc && g >= 0) exp_rdy[g] = 1'b1;
    chk("ins_ready", 64'(ins_ready), 64'(exp_rdy));
    chk("outs_valid", 64'(outs_valid), 64'(m_full));
    if (rst) begin
      sb.delete();
      m_full = 1'b0;
      m_rr   = 0;
    end else begin
      if (m_full && outs_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_outs", 64'(outs), 64'(e[DW+IW-1:IW]));
        chk("sb_index", 64'(index), 64'(e[IW-1:0]));
      end
      if (acc && g >= 0) begin
        sb.push_back({ins[g*DW +: DW], IW'(g)});
        m_rr   = (g + 1) % N;
        m_full = 1'b1;
      end else if (m_full && outs_ready) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    ins_valid  = '1;
    outs_ready = 1'b1;
    for (int i = 0; i < N; i++) ins[i*DW +: DW] = DW'(32'h10 + i);
    @(posedge clk);
    #1;

    // Reset held two cycles with every input requesting
    step();
    step();
    chk("rst_outs", 64'(outs), 64'h0);
    chk("rst_index", 64'(index), 64'h0);
    rst = 1'b0;

    // All inputs requesting: strict rotation, one token per cycle
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_index", 64'(index), 64'(k % 4));
      chk("rr_outs", 64'(outs), 64'(32'h10 + (k % 4)));
      chk("rr_valid", 64'(outs_valid), 64'h1);
    end

    // Only inputs 1 and 3: alternate, wrapping past the end
    ins_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("skip_index", 64'(index), (k % 2 == 0) ? 64'h1 : 64'h3);
    end

    // Load input 2 with DEAD, then stall with inputs 0 and 3 pending
    ins_valid        = 4'b0100;
    ins[2*DW +: DW]  = 32'hDEAD;
    step();
    chk("bp_load_index", 64'(index), 64'h2);
    ins_valid  = 4'b1001;
    outs_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_outs", 64'(outs), 64'hDEAD);
      chk("bp_index", 64'(index), 64'h2);
      chk("bp_valid", 64'(outs_valid), 64'h1);
    end
    outs_ready = 1'b1;
    step();
    chk("bp_reload_index", 64'(index), 64'h3);
    chk("bp_reload_outs", 64'(outs), 64'h13);

    // Reset while the slot holds a token from input 1
    ins_valid = 4'b0010;
    step();
    chk("mid_fill_index", 64'(index), 64'h1);
    ins_valid  = '0;
    outs_ready = 1'b0;
    rst        = 1'b1;
    step();
    chk("mid_rst_valid", 64'(outs_valid), 64'h0);
    rst        = 1'b0;
    outs_ready = 1'b1;
    ins_valid  = 4'b1110;
    step();
    chk("mid_rst_ptr_index", 64'(index), 64'h1);
    ins_valid = '0;
    step();
    step();
    chk("drain_valid", 64'(outs_valid), 64'h0);

`ifdef HANDSHAKE_RR_CMERGE_GRANT_CNT_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ins_valid = 4'b0001;
    repeat (70000) @(posedge clk);
    #1;
    ins_valid = '0;
    chk("cnt0_saturated", 64'(grant_cnt[15:0]), 64'hFFFF);
    chk("cnt_others_zero", 64'(grant_cnt[N*16-1:16]), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
